// File: rtl/decoder_pkg.sv
// Shared types for the scanning one-hot decoder.
// Holds the FSM state enum and the default-width one-hot helper.
package decoder_pkg;

    localparam int DEF_SEL_W = 3;
    localparam int DEF_OUT_W = 2 ** DEF_SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        STATIC,
        DRIVE,
        BLANK
    } state_t;

    function automatic logic [DEF_OUT_W-1:0] onehot(
        input logic [DEF_SEL_W-1:0] sel
    );
        logic [DEF_OUT_W-1:0] y;
        y      = '0;
        y[sel] = 1'b1;
        return y;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
// Disabled output is all-zero; polarity is applied by the caller.
import decoder_pkg::*;

module decoder_onehot #(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   y
);

    logic [2**SEL_W-1:0] hot;

    generate
        if (SEL_W == DEF_SEL_W) begin : g_pkg
            assign hot = onehot(sel);
        end else begin : g_shift
            assign hot = {{(2**SEL_W-1){1'b0}}, 1'b1} << sel;
        end
    endgenerate

    assign y = en ? hot : '0;

endmodule

// File: rtl/decoder_scan_n.sv
// One-hot decoder with static and auto-scan modes for multiplexed displays.
// All outputs are registered from the next-state decode.
import decoder_pkg::*;

module decoder_scan_n #(
    parameter int SEL_W     = DEF_SEL_W,
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic [SEL_W-1:0]     i_sel,
    input  logic                 i_opt,
    input  logic [DWELL_W-1:0]   i_dwell,
    input  logic [SEL_W-1:0]     i_last,
    output logic [2**SEL_W-1:0]  o_y,
    output logic [SEL_W-1:0]     o_idx,
    output logic                 o_valid,
    output logic                 o_wrap
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam int BLK_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST =
        BLK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t             state;
    state_t             state_nx;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   idx_nx;
    logic [SEL_W-1:0]   idx_adv;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_nx;
    logic [DWELL_W-1:0] dwell_eff;
    logic [BLK_W-1:0]   blank_cnt;
    logic [BLK_W-1:0]   blank_nx;
    logic               wrap_nx;
    logic               dwell_done;
    logic               at_end;
    logic               active;
    logic [OUT_W-1:0]   hot;

    // Dwell of zero behaves as one cycle; limits are sampled live.
    assign dwell_eff  = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign dwell_done = dwell_cnt >= (dwell_eff - DWELL_W'(1));
    assign at_end     = idx >= i_last;
    assign idx_adv    = at_end ? '0 : idx + SEL_W'(1);
    assign active     = (state_nx == STATIC) || (state_nx == DRIVE);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dwell_nx = dwell_cnt;
        blank_nx = blank_cnt;
        wrap_nx  = 1'b0;
        if (!i_en) begin
            state_nx = IDLE;
            idx_nx   = '0;
            dwell_nx = '0;
            blank_nx = '0;
        end else if (!i_mode) begin
            state_nx = STATIC;
            idx_nx   = i_sel;
            dwell_nx = '0;
            blank_nx = '0;
        end else begin
            unique case (state)
                IDLE, STATIC: begin
                    state_nx = DRIVE;
                    idx_nx   = '0;
                    dwell_nx = '0;
                    blank_nx = '0;
                end
                DRIVE: begin
                    if (!dwell_done) begin
                        dwell_nx = dwell_cnt + DWELL_W'(1);
                    end else if (BLANK_CYC > 0) begin
                        state_nx = BLANK;
                        dwell_nx = '0;
                        blank_nx = '0;
                    end else begin
                        idx_nx   = idx_adv;
                        dwell_nx = '0;
                        wrap_nx  = at_end;
                    end
                end
                BLANK: begin
                    if (blank_cnt >= BLK_LAST) begin
                        state_nx = DRIVE;
                        idx_nx   = idx_adv;
                        blank_nx = '0;
                        wrap_nx  = at_end;
                    end else begin
                        blank_nx = blank_cnt + BLK_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    dwell_nx = '0;
                    blank_nx = '0;
                end
            endcase
        end
    end

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel (idx_nx),
        .en  (active),
        .y   (hot)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            o_y       <= '1;
            o_valid   <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            dwell_cnt <= dwell_nx;
            blank_cnt <= blank_nx;
            o_y       <= i_opt ? hot : ~hot;
            o_valid   <= active;
            o_wrap    <= wrap_nx;
        end
    end

    assign o_idx = idx;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Randomised and directed bench for decoder_scan_n.
// Expected outputs come from a slot/gap model of the scan behaviour.
module tb_decoder_scan_n;

    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic        opt;
    logic [15:0] dwell;
    logic [2:0]  last;
    logic [7:0]  o_y;
    logic [2:0]  o_idx;
    logic        o_valid;
    logic        o_wrap;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit   m_run;
    bit   m_in_gap;
    int   m_gap;
    int   m_held;
    int   m_idx;
    logic [7:0] e_y;
    logic [2:0] e_idx;
    logic       e_valid;
    logic       e_wrap;

    always #5 clk = ~clk;

    decoder_scan_n #(
        .SEL_W     (3),
        .DWELL_W   (16),
        .BLANK_CYC (BLANK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_mode  (mode),
        .i_sel   (sel),
        .i_opt   (opt),
        .i_dwell (dwell),
        .i_last  (last),
        .o_y     (o_y),
        .o_idx   (o_idx),
        .o_valid (o_valid),
        .o_wrap  (o_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int eff;
        logic [7:0] h;
        eff    = (dwell == 0) ? 1 : int'(dwell);
        e_wrap = 1'b0;
        if (!rst_n) begin
            m_run   = 0;
            m_idx   = 0;
            e_valid = 1'b0;
        end else if (!en) begin
            m_run   = 0;
            m_idx   = 0;
            e_valid = 1'b0;
        end else if (!mode) begin
            m_run   = 0;
            m_idx   = int'(sel);
            e_valid = 1'b1;
        end else if (!m_run) begin
            m_run    = 1;
            m_in_gap = 0;
            m_idx    = 0;
            m_held   = 1;
            e_valid  = 1'b1;
        end else if (m_in_gap && m_gap < BLANK) begin
            m_gap++;
            e_valid = 1'b0;
        end else if (!m_in_gap && m_held < eff) begin
            m_held++;
            e_valid = 1'b1;
        end else if (!m_in_gap && BLANK > 0) begin
            m_in_gap = 1;
            m_gap    = 1;
            e_valid  = 1'b0;
        end else begin
            e_wrap   = (m_idx >= int'(last));
            m_idx    = e_wrap ? 0 : m_idx + 1;
            m_in_gap = 0;
            m_held   = 1;
            e_valid  = 1'b1;
        end
        e_idx = 3'(m_idx);
        h     = e_valid ? (8'd1 << m_idx) : 8'd0;
        if (!rst_n) e_y = 8'hFF;
        else        e_y = opt ? h : ~h;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check("y", {24'd0, o_y}, {24'd0, e_y});
            check("idx", {29'd0, o_idx}, {29'd0, e_idx});
            check("valid", {31'd0, o_valid}, {31'd0, e_valid});
            check("wrap", {31'd0, o_wrap}, {31'd0, e_wrap});
        end
    endtask

    initial begin
        int last_w;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b1;
        sel   = 3'd0;
        opt   = 1'b1;
        dwell = 16'd3;
        last  = 3'd7;

        cyc(3);
        check("rst_y", {24'd0, o_y}, 32'hFF);

        rst_n = 1'b1;
        mode  = 1'b0;
        opt   = 1'b0;
        sel   = 3'd5;
        cyc(1);
        check("static_df", {24'd0, o_y}, 32'hDF);
        opt = 1'b1;
        cyc(1);
        check("static_20", {24'd0, o_y}, 32'h20);

        mode   = 1'b1;
        last_w = -1;
        for (int i = 0; i < 130; i++) begin
            cyc(1);
            if (o_wrap) begin
                check("wrap_y", {24'd0, o_y}, 32'h01);
                if (last_w >= 0) check("frame", i - last_w, 40);
                last_w = i;
            end
        end

        for (int i = 0; i < 80 && !(o_valid && o_idx == 3'd6); i++) cyc(1);
        check("reach6", {29'd0, o_idx}, 32'd6);
        last = 3'd3;
        for (int i = 0; i < 20 && (!o_valid || o_idx == 3'd6); i++) cyc(1);
        check("shrink_idx", {29'd0, o_idx}, 32'd0);
        check("shrink_wrap", {31'd0, o_wrap}, 32'd1);

        dwell = 16'd0;
        last  = 3'd7;
        cyc(20);

        dwell = 16'd3;
        for (int i = 0; i < 80 && !(o_valid && o_idx == 3'd4); i++) cyc(1);
        check("reach4", {29'd0, o_idx}, 32'd4);
        en = 1'b0;
        cyc(1);
        check("abort_y", {24'd0, o_y}, 32'h00);
        check("abort_idx", {29'd0, o_idx}, 32'd0);
        en = 1'b1;
        cyc(1);
        check("reen_y", {24'd0, o_y}, 32'h01);
        check("reen_wrap", {31'd0, o_wrap}, 32'd0);

        for (int i = 0; i < 10 && o_valid; i++) cyc(1);
        check("in_blank", {31'd0, o_valid}, 32'd0);
        mode = 1'b0;
        sel  = 3'd2;
        opt  = 1'b0;
        cyc(1);
        check("switch_fb", {24'd0, o_y}, 32'hFB);
        mode = 1'b1;
        cyc(3);
        check("rescan_idx", {29'd0, o_idx}, 32'd0);
        check("rescan_valid", {31'd0, o_valid}, 32'd1);
        cyc(1);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) opt = ~opt;
            if ($urandom_range(0, 49) == 0) dwell = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) last = 3'($urandom_range(0, 7));
            sel = 3'($urandom_range(0, 7));
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
